// File: rtl/bench_seq_sched.sv
// ---------------------------------------------------------------------------
// bench_seq_sched
//
// Two-requester round-robin scheduler and sequencer for the 6-bit
// XOR-accumulating benchmark datapath (next_state = state ^ in[5:0]).
// One job runs at a time. Each job clears the datapath for one cycle, then
// applies the job's input vector for LEN cycles. It then captures the
// datapath output and returns it to the requester that owns the job.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   req       in   [1:0]   per-requester level request, held until gnt
//   vec0/1    in   [IN_W]  requester input vectors, stable while requesting
//   len0/1    in   [LEN_W] requester run lengths in datapath cycles
//   gnt       out  [1:0]   one-hot pulse: job accepted, inputs latched
//   done      out  [1:0]   one-hot pulse: result valid for that requester
//   result    out  [OUT_W] captured datapath output, held until next capture
//   busy      out  high while a job is in CLEAR/RUN/CAPTURE
//   dp_in     out  [IN_W]  drives datapath `in`
//   dp_rst_n  out  drives datapath active-low `reset`
//   dp_out    in   [OUT_W] datapath `out`
//
// Every output is a register. The output process computes the value that
// each output register takes at the next edge.
// ---------------------------------------------------------------------------
module bench_seq_sched #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 7,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [IN_W-1:0]  vec0,
    input  logic [IN_W-1:0]  vec1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [OUT_W-1:0] result,
    output logic             busy,
    output logic [IN_W-1:0]  dp_in,
    output logic             dp_rst_n,
    input  logic [OUT_W-1:0] dp_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Job context latched at grant time
    logic             owner_q,  owner_d;
    logic [IN_W-1:0]  vec_q,    vec_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic             rr_ptr_q, rr_ptr_d;

    // Output registers
    logic [1:0]       gnt_q,    gnt_d;
    logic [1:0]       done_q,   done_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic [IN_W-1:0]  dp_in_q,  dp_in_d;
    logic             dp_rst_n_q, dp_rst_n_d;

    // Arbitration: a lone request wins outright; a tie goes to rr_ptr.
    logic any_req;
    logic win;

    always_comb begin
        any_req = |req;
        win     = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = rr_ptr_q;
            default: win = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // cnt_q still holds the full job length here.
                // A zero-length job skips RUN entirely.
                if (cnt_q != '0) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_RUN: begin
                // The count is at 1 on the last of the len RUN cycles.
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / context logic
    // ------------------------------------------------------------------
    always_comb begin
        owner_d  = owner_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        result_d = result_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    vec_d   = win ? vec1 : vec0;
                    cnt_d   = win ? len1 : len0;
                    gnt_d   = win ? 2'b10 : 2'b01;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - LEN_W'(1);
            end
            S_CAPTURE: begin
                result_d = dp_out;
                done_d   = owner_q ? 2'b10 : 2'b01;
                // Priority moves away from the requester just served, and
                // only when a job completes.
                rr_ptr_d = ~owner_q;
            end
            default: begin
            end
        endcase

        // The datapath-facing outputs follow the state being entered,
        // so they line up with that state's cycle.
        busy_d     = (state_d != S_IDLE);
        dp_rst_n_d = (state_d != S_CLEAR);
        dp_in_d    = (state_d == S_RUN) ? vec_q : '0;
    end

    // ------------------------------------------------------------------
    // Context and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= 1'b0;
            vec_q      <= '0;
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            result_q   <= '0;
            busy_q     <= 1'b0;
            dp_in_q    <= '0;
            // Keeps the datapath cleared while this block is held in reset.
            dp_rst_n_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            dp_in_q    <= dp_in_d;
            dp_rst_n_q <= dp_rst_n_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign dp_in    = dp_in_q;
    assign dp_rst_n = dp_rst_n_q;

endmodule

// File: tb/tb_bench_seq_sched.sv
module tb_bench_seq_sched;

    localparam int IN_W  = 19;
    localparam int OUT_W = 7;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [IN_W-1:0]  vec0, vec1;
    logic [LEN_W-1:0] len0, len1;
    logic [1:0]       gnt, done;
    logic [OUT_W-1:0] result;
    logic             busy;
    logic [IN_W-1:0]  dp_in;
    logic             dp_rst_n;
    logic [OUT_W-1:0] dp_out;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bench_seq_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req(req),
        .vec0(vec0), .vec1(vec1), .len0(len0), .len1(len1),
        .gnt(gnt), .done(done), .result(result), .busy(busy),
        .dp_in(dp_in), .dp_rst_n(dp_rst_n), .dp_out(dp_out)
    );

    // Behavioural benchmark datapath: 6-bit XOR accumulator
    logic [5:0] dp_st;
    always_ff @(posedge clk or negedge dp_rst_n) begin
        if (!dp_rst_n) dp_st <= 6'd0;
        else           dp_st <= dp_st ^ dp_in[5:0];
    end
    assign dp_out = {1'b0, dp_st};

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},    32'(gnt),      32'd0);
        chk({tag, "_done"},   32'(done),     32'd0);
        chk({tag, "_result"}, 32'(result),   32'd0);
        chk({tag, "_busy"},   32'(busy),     32'd0);
        chk({tag, "_dp_in"},  32'(dp_in),    32'd0);
        chk({tag, "_dp_rst"}, 32'(dp_rst_n), 32'd0);
    endtask

    // Issue a single job from requester r while the scheduler is idle and
    // check every cycle up to and just past done.
    task automatic run_job(input int r, input logic [IN_W-1:0] v,
                           input logic [LEN_W-1:0] l, input logic [OUT_W-1:0] exp);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        if (r == 1) begin vec1 = v; len1 = l; end
        else        begin vec0 = v; len0 = l; end
        req = oh;
        tick;                                   // T+1: grant, CLEAR
        chk("gnt",       32'(gnt),      32'(oh));
        chk("clr_rst_n", 32'(dp_rst_n), 32'd0);
        chk("clr_dp_in", 32'(dp_in),    32'd0);
        chk("clr_busy",  32'(busy),     32'd1);
        req  = 2'b00;
        // Later changes to the job inputs must be ignored
        vec0 = ~v;
        vec1 = ~v;
        len0 = l ^ 8'h5A;
        len1 = l ^ 8'hA5;
        for (int i = 0; i < int'(l); i++) begin
            tick;                               // RUN cycles
            chk("run_dp_in", 32'(dp_in),    32'(v));
            chk("run_rst_n", 32'(dp_rst_n), 32'd1);
            if (i == 0) chk("gnt_pulse", 32'(gnt), 32'd0);
        end
        tick;                                   // CAPTURE
        chk("cap_dp_in", 32'(dp_in), 32'd0);
        chk("cap_done",  32'(done),  32'd0);
        chk("cap_busy",  32'(busy),  32'd1);
        tick;                                   // T+len+3
        chk("done",     32'(done),   32'(oh));
        chk("result",   32'(result), 32'(exp));
        chk("done_gnt", 32'(gnt),    32'd0);
        chk("idle_busy",32'(busy),   32'd0);
        tick;
        chk("done_pulse",  32'(done),   32'd0);
        chk("result_hold", 32'(result), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        vec0  = '0;
        vec1  = '0;
        len0  = '0;
        len1  = '0;

        // Reset state
        tick;
        tick;
        chk_reset_vals("rst");
        reset = 1'b1;
        tick;
        chk("post_rst_rst_n", 32'(dp_rst_n), 32'd1);
        chk("post_rst_busy",  32'(busy),     32'd0);
        chk("post_rst_gnt",   32'(gnt),      32'd0);

        // Single jobs: odd, even and zero length
        run_job(0, 19'h0002A, 8'd3, 7'h2A);
        run_job(0, 19'h0002A, 8'd4, 7'h00);
        run_job(0, 19'h0002A, 8'd0, 7'h00);

        // Fresh reset so round robin starts from requester 0
        #1 reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;

        // Continuous dual requests alternate 0,1,0,1
        vec0 = 19'h00015; len0 = 8'd1;
        vec1 = 19'h0003F; len1 = 8'd1;
        req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick;                               // grant
            chk("rr_gnt",  32'(gnt),  (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("rr_done0",32'(done), 32'd0);
            tick;                               // RUN
            tick;                               // CAPTURE
            tick;                               // done
            chk("rr_done",   32'(done),   (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("rr_result", 32'(result), (k % 2 == 1) ? 32'h3F : 32'h15);
            chk("rr_nognt",  32'(gnt),    32'd0);
        end
        req = 2'b00;
        tick;
        tick;

        // Request raised and withdrawn between edges is never granted
        #1 req = 2'b01;
        #3 req = 2'b00;
        tick;
        chk("wd_gnt",  32'(gnt),  32'd0);
        chk("wd_busy", 32'(busy), 32'd0);
        tick;
        chk("wd_gnt2", 32'(gnt),  32'd0);
        run_job(1, 19'h0003F, 8'd1, 7'h3F);

        // Reset in the middle of a long job
        vec0 = 19'h0002A; len0 = 8'd200;
        req  = 2'b01;
        tick;
        chk("ab_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (10) tick;
        chk("ab_busy",  32'(busy),  32'd1);
        chk("ab_dp_in", 32'(dp_in), 32'h2A);
        #1 reset = 1'b0;
        #1 chk_reset_vals("abort");
        tick;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("ab_nodone", 32'(done), 32'd0);
            chk("ab_idle",   32'(busy), 32'd0);
        end
        run_job(0, 19'h00015, 8'd1, 7'h15);

        // Maximum length with upper vector bits set
        run_job(0, 19'h7FFC1, 8'd255, 7'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bench_seq_sched.md
Name: bench_seq_sched

Overview:
- Two-requester round-robin scheduler and sequencer for the 6-bit XOR-accumulating benchmark datapath (`next_state = state ^ in[5:0]`).
- Grants one job at a time: clear datapath -> apply the job's input vector for LEN cycles -> capture datapath output -> return result to the owning requester.
- Sits between functional/test requesters and a `bench_seq` instance; drives its `in` and `reset`, observes its `out`.

Parameters:
- IN_W, 19, width of datapath input vector
- OUT_W, 7, width of datapath output / captured result
- LEN_W, 8, width of per-job run-length field

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- req  in  2  per-requester job request, level, held until gnt
- vec0  in  IN_W  requester 0 input vector, stable while req[0]=1
- vec1  in  IN_W  requester 1 input vector, stable while req[1]=1
- len0  in  LEN_W  requester 0 run length (datapath clock cycles)
- len1  in  LEN_W  requester 1 run length
- gnt  out  2  one-hot, one-cycle pulse: job accepted, inputs latched
- done  out  2  one-hot, one-cycle pulse: result valid for that requester
- result  out  OUT_W  captured datapath output, held until next capture
- busy  out  1  high in CLEAR/RUN/CAPTURE
- dp_in  out  IN_W  to datapath `in`
- dp_rst_n  out  1  to datapath active-low `reset`
- dp_out  in  OUT_W  from datapath `out`

Behaviour:
- All outputs registered.
- Reset (async, low) values: gnt=0, done=0, result=0, busy=0, dp_in=0, dp_rst_n=0, FSM=IDLE, rr_ptr=0.
  - dp_rst_n=0 holds the datapath cleared while this block is in reset.
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
- IDLE:
  - dp_in=0, so the datapath state holds; dp_rst_n=1.
  - If any req bit is set, pick winner w:
    - Only one bit set -> that requester.
    - Both set -> requester rr_ptr.
  - At that edge: latch vec_w/len_w, gnt[w]=1 for the next cycle, FSM -> CLEAR.
- CLEAR:
  - Exactly 1 cycle; dp_rst_n=0, dp_in=0, busy=1.
  - Next: RUN if latched len != 0, else CAPTURE.
- RUN:
  - dp_rst_n=1, dp_in = latched vec for exactly len consecutive cycles.
  - Down-counter loaded with len; leave on the cycle count reaches 1; dp_in returns to 0 on exit.
- CAPTURE:
  - 1 cycle, dp_in=0. At its closing edge: result <= dp_out, done[w]=1 for the next cycle, rr_ptr <= ~w, FSM -> IDLE.
  - Resulting datapath value: len odd -> {0, vec[5:0]}; len even, including 0 -> 0.
- Latency:
  - req seen in IDLE at cycle T -> gnt at T+1 -> done/result at T+len+3.
  - Back-to-back jobs: next gnt no earlier than 1 cycle after done.
- req sampling:
  - req is sampled only in IDLE.
  - Deassertion before gnt withdraws the request, no penalty.
  - Changes to vec/len after gnt are ignored.
- Fairness: rr_ptr updates only on completion. Under continuous dual requests, grants strictly alternate 0,1,0,1 starting with 0 after reset.
- Simultaneous events: done for job k and gnt for job k+1 never coincide; at most one gnt bit and one done bit high per cycle.
- Reset mid-job: immediate abort to reset values. No done is issued for the aborted job; result returns to 0.
- len arithmetic: unsigned; max 2^LEN_W-1 cycles. No overflow possible, counter width LEN_W.
- Upper bits: vec bits above [5:0] are driven to dp_in unchanged. Only [5:0] affect the datapath.

Test Plan:
- Reset then req=01, vec0=19'h0002A, len0=3 -> gnt=01 at T+1, dp_rst_n low 1 cycle, dp_in=0002A for 3 cycles, done=01 at T+6, result=7'h2A.
- Same with len0=4 -> done at T+7, result=7'h00; len0=0 -> done at T+3, result=0.
- req=11 held; vec0=19'h00015, len0=1; vec1=19'h0003F, len1=1 -> grants 0,1,0,1; results alternate 7'h15, 7'h3F.
- req=01 raised, dropped before gnt, then req=10 -> only gnt=10; no done for requester 0.
- Assert reset during RUN of a len=200 job -> all outputs return to reset values immediately; after release, IDLE with no done; next job completes normally.
- len0=255, vec0=19'h7FFC1 -> dp_in=7FFC1 for exactly 255 cycles, result=7'h01.
